// File: rtl/video_sync_decoder.sv
// Sync decoder for VIC6569 video: recovers line/frame timing from hsync/vsync,
// locks onto stable timing, streams active-area pixels and a per-frame checksum.
module video_sync_decoder #(
  parameter bit          H_POL       = 1'b1,
  parameter bit          V_POL       = 1'b1,
  parameter int unsigned CW          = 10,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned H_ACT_START = 4,
  parameter int unsigned H_ACT_LEN   = 12,
  parameter int unsigned V_ACT_START = 2,
  parameter int unsigned V_ACT_LEN   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic [3:0]    i_red,
  input  logic [3:0]    i_green,
  input  logic [3:0]    i_blue,
  output logic [CW-1:0] o_hpos,
  output logic [CW-1:0] o_vpos,
  output logic [CW-1:0] o_line_len,
  output logic [CW-1:0] o_frame_lines,
  output logic          o_locked,
  output logic          o_pixel_valid,
  output logic [11:0]   o_pixel,
  output logic          o_frame_done,
  output logic [15:0]   o_frame_sum,
  output logic [7:0]    o_err_count
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [CW:0] H_LO   = (CW+1)'(H_ACT_START);
  localparam logic [CW:0] H_HI   = (CW+1)'(H_ACT_START + H_ACT_LEN);
  localparam logic [CW:0] V_LO   = (CW+1)'(V_ACT_START);
  localparam logic [CW:0] V_HI   = (CW+1)'(V_ACT_START + V_ACT_LEN);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  state_t        state_q, state_d;
  logic          hs_q, hs_d, hs_prev_q, hs_prev_d;
  logic          vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [CW-1:0] line_ref_q, line_ref_d, frame_ref_q, frame_ref_d;
  logic          line_ref_vld_q, line_ref_vld_d, frame_bad_q, frame_bad_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d, lock_cnt_nxt;
  logic [11:0]   pix_q, pix_d;
  logic          pix_vld_q, pix_vld_d;
  logic [CW-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [15:0]   acc_q, acc_d, sum_q, sum_d;
  logic          done_q, done_d;
  logic [7:0]    err_q, err_d;

  logic          hs_edge, vs_edge, hcnt_max, line_bad, frame_mis, h_act, v_act;
  logic [CW-1:0] line_meas, frame_meas;

  always_comb begin
    hs_edge    = hs_q & ~hs_prev_q;
    vs_edge    = vs_q & ~vs_prev_q;
    hcnt_max   = (hcnt_q == '1);
    line_meas  = hcnt_q + 1'b1;
    frame_meas = vcnt_q + 1'b1;
    // A saturated counter is treated like a bad line: the line never ended.
    line_bad   = (hs_edge & line_ref_vld_q & (line_meas != line_ref_q)) | hcnt_max;
    frame_mis  = vs_edge & (frame_meas != frame_ref_q);
    h_act      = ({1'b0, hcnt_q} >= H_LO) && ({1'b0, hcnt_q} < H_HI);
    v_act      = ({1'b0, vcnt_q} >= V_LO) && ({1'b0, vcnt_q} < V_HI);
  end

  always_comb begin
    state_d        = state_q;
    hs_d           = (i_hsync == H_POL);
    vs_d           = (i_vsync == V_POL);
    hs_prev_d      = hs_q;
    vs_prev_d      = vs_q;
    rgb_d          = {i_red, i_green, i_blue};
    line_ref_d     = line_ref_q;
    frame_ref_d    = frame_ref_q;
    line_ref_vld_d = line_ref_vld_q;
    frame_bad_d    = frame_bad_q;
    lock_cnt_d     = lock_cnt_q;
    lock_cnt_nxt   = lock_cnt_q;
    sum_d          = sum_q;
    done_d         = 1'b0;
    err_d          = err_q;
    acc_d          = pix_vld_q ? acc_q + {4'b0, pix_q} : acc_q;

    if (hs_edge)       hcnt_d = '0;
    else if (hcnt_max) hcnt_d = hcnt_q;
    else               hcnt_d = hcnt_q + 1'b1;

    if (vs_edge)      vcnt_d = '0;
    else if (hs_edge) vcnt_d = vcnt_q + 1'b1;
    else              vcnt_d = vcnt_q;

    case (state_q)
      SEARCH: begin
        line_ref_vld_d = 1'b0;
        frame_bad_d    = 1'b0;
        lock_cnt_d     = '0;
        if (vs_edge) state_d = MEASURE;
      end
      MEASURE: begin
        if (line_bad) begin
          lock_cnt_d     = '0;
          line_ref_vld_d = 1'b0;
          frame_bad_d    = 1'b1;
        end else if (hs_edge && !line_ref_vld_q) begin
          line_ref_d     = line_meas;
          line_ref_vld_d = 1'b1;
        end
        if (vs_edge) begin
          frame_bad_d = 1'b0;
          if (!frame_bad_q && !line_bad) begin
            if (lock_cnt_q == '0 || frame_meas == frame_ref_q) lock_cnt_nxt = lock_cnt_q + 1'b1;
            else                                               lock_cnt_nxt = 8'd1;
            lock_cnt_d  = lock_cnt_nxt;
            frame_ref_d = frame_meas;
            if (lock_cnt_nxt >= LOCK_N) begin
              state_d = LOCKED;
              acc_d   = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (line_bad || frame_mis) begin
          state_d = SEARCH;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 1'b1;
        end else if (vs_edge) begin
          // Any pixel landing on this cycle is in blanking and is dropped.
          sum_d  = acc_q;
          done_d = 1'b1;
          acc_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    pix_d     = rgb_q;
    pix_vld_d = (state_q == LOCKED) && h_act && v_act;
    hpos_d    = (state_q == LOCKED) ? hcnt_q : '0;
    vpos_d    = (state_q == LOCKED) ? vcnt_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SEARCH;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      hs_prev_q      <= 1'b0;
      vs_prev_q      <= 1'b0;
      rgb_q          <= '0;
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      line_ref_q     <= '0;
      frame_ref_q    <= '0;
      line_ref_vld_q <= 1'b0;
      frame_bad_q    <= 1'b0;
      lock_cnt_q     <= '0;
      pix_q          <= '0;
      pix_vld_q      <= 1'b0;
      hpos_q         <= '0;
      vpos_q         <= '0;
      acc_q          <= '0;
      sum_q          <= '0;
      done_q         <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      hs_prev_q      <= hs_prev_d;
      vs_prev_q      <= vs_prev_d;
      rgb_q          <= rgb_d;
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      line_ref_q     <= line_ref_d;
      frame_ref_q    <= frame_ref_d;
      line_ref_vld_q <= line_ref_vld_d;
      frame_bad_q    <= frame_bad_d;
      lock_cnt_q     <= lock_cnt_d;
      pix_q          <= pix_d;
      pix_vld_q      <= pix_vld_d;
      hpos_q         <= hpos_d;
      vpos_q         <= vpos_d;
      acc_q          <= acc_d;
      sum_q          <= sum_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign o_locked      = (state_q == LOCKED);
  assign o_line_len    = o_locked ? line_ref_q  : '0;
  assign o_frame_lines = o_locked ? frame_ref_q : '0;
  assign o_hpos        = hpos_q;
  assign o_vpos        = vpos_q;
  assign o_pixel       = pix_q;
  assign o_pixel_valid = pix_vld_q;
  assign o_frame_done  = done_q;
  assign o_frame_sum   = sum_q;
  assign o_err_count   = err_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder: drives 20x10 frames into an active-high and an
// active-low sync instance, scoreboarding pixels, frame sums and lock status.
module tb_video_sync_decoder;

  localparam int CW = 10;

  logic clk = 1'b0;
  logic reset;
  logic hs, vs;
  logic [3:0] r, g, b;

  logic [CW-1:0] hpos0, vpos0, llen0, flines0, hpos1, vpos1, llen1, flines1;
  logic          lock0, pv0, fd0, lock1, pv1, fd1;
  logic [11:0]   pix0, pix1;
  logic [15:0]   fsum0, fsum1;
  logic [7:0]    err0, err1;

  always #5 clk = ~clk;

  video_sync_decoder dut0 (
    .clk(clk), .reset(reset), .i_hsync(hs), .i_vsync(vs),
    .i_red(r), .i_green(g), .i_blue(b),
    .o_hpos(hpos0), .o_vpos(vpos0), .o_line_len(llen0), .o_frame_lines(flines0),
    .o_locked(lock0), .o_pixel_valid(pv0), .o_pixel(pix0),
    .o_frame_done(fd0), .o_frame_sum(fsum0), .o_err_count(err0)
  );

  video_sync_decoder #(.H_POL(1'b0), .V_POL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .i_hsync(~hs), .i_vsync(~vs),
    .i_red(r), .i_green(g), .i_blue(b),
    .o_hpos(hpos1), .o_vpos(vpos1), .o_line_len(llen1), .o_frame_lines(flines1),
    .o_locked(lock1), .o_pixel_valid(pv1), .o_pixel(pix1),
    .o_frame_done(fd1), .o_frame_sum(fsum1), .o_err_count(err1)
  );

  typedef struct {
    logic [11:0] pix;
    int          hpos;
    int          vpos;
  } exp_pix_t;

  typedef struct {
    bit pat;
    int bad_line;
    bit push_pix;
    bit push_sum;
    bit exp_lock;
    int exp_err;
    int exp_len;
    int exp_lines;
  } vec_t;

  exp_pix_t    pq0[$], pq1[$];
  logic [15:0] sq0[$], sq1[$];
  int          n_pass = 0;
  int          n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic mon_pix(input int k, input logic [11:0] p, input logic [CW-1:0] hp,
                         input logic [CW-1:0] vp);
    exp_pix_t e;
    int       avail;
    avail = (k == 0) ? pq0.size() : pq1.size();
    chk($sformatf("pixel_expected%0d", k), int'(avail > 0), 1);
    if (avail > 0) begin
      e = (k == 0) ? pq0.pop_front() : pq1.pop_front();
      chk($sformatf("pixel%0d", k), int'(p), int'(e.pix));
      chk($sformatf("hpos%0d", k), int'(hp), e.hpos);
      chk($sformatf("vpos%0d", k), int'(vp), e.vpos);
    end
  endtask

  task automatic mon_sum(input int k, input logic [15:0] s);
    int          avail;
    logic [15:0] e;
    avail = (k == 0) ? sq0.size() : sq1.size();
    chk($sformatf("sum_expected%0d", k), int'(avail > 0), 1);
    if (avail > 0) begin
      e = (k == 0) ? sq0.pop_front() : sq1.pop_front();
      chk($sformatf("frame_sum%0d", k), int'(s), int'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (pv0) mon_pix(0, pix0, hpos0, vpos0);
      if (pv1) mon_pix(1, pix1, hpos1, vpos1);
      if (fd0) mon_sum(0, fsum0);
      if (fd1) mon_sum(1, fsum1);
    end
  end

  task automatic cyc(input logic h, input logic v, input logic [11:0] rgb);
    hs = h;
    vs = v;
    {r, g, b} = rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input bit lk, input int err,
                              input int len, input int lines);
    chk({tag, "_locked0"}, int'(lock0), int'(lk));
    chk({tag, "_locked1"}, int'(lock1), int'(lk));
    chk({tag, "_err0"}, int'(err0), err);
    chk({tag, "_err1"}, int'(err1), err);
    chk({tag, "_line_len0"}, int'(llen0), len);
    chk({tag, "_line_len1"}, int'(llen1), len);
    chk({tag, "_frame_lines0"}, int'(flines0), lines);
    chk({tag, "_frame_lines1"}, int'(flines1), lines);
  endtask

  // Line y, clock x: hsync on x=0..1, vsync on line 0. The decoder's hcnt for
  // the sample at x is x-1, so active pixels sit at x=5..16 on lines 2..7.
  task automatic drive_frame(input bit pat, input int bad_line, input bit push_pix,
                             input bit push_sum, input int n_lines);
    logic [15:0] sum;
    logic [11:0] c;
    exp_pix_t    e;
    int          len;
    sum = '0;
    for (int y = 0; y < n_lines; y++) begin
      len = (y == bad_line) ? 21 : 20;
      for (int x = 0; x < len; x++) begin
        c = pat ? {4'(x), 4'(y), 4'hA} : 12'hF00;
        if (push_pix && x >= 5 && x <= 16 && y >= 2 && y <= 7) begin
          e.pix  = c;
          e.hpos = x - 1;
          e.vpos = y;
          pq0.push_back(e);
          pq1.push_back(e);
          sum = sum + {4'b0, c};
        end
        cyc(x < 2, y == 0, c);
        if (bad_line >= 0 && y == bad_line + 1 && x == 0) begin
          chk("lock_at_bad_edge0", int'(lock0), 1);
          chk("lock_at_bad_edge1", int'(lock1), 1);
        end
        if (bad_line >= 0 && y == bad_line + 1 && x == 1) begin
          chk("lock_drop0", int'(lock0), 0);
          chk("lock_drop1", int'(lock1), 0);
        end
      end
    end
    if (push_sum) begin
      sq0.push_back(sum);
      sq1.push_back(sum);
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{1'b0, -1, 1'b0, 1'b0, 1'b0, 0,  0,  0};
    vt[1] = '{1'b0, -1, 1'b0, 1'b0, 1'b0, 0,  0,  0};
    vt[2] = '{1'b0, -1, 1'b1, 1'b1, 1'b1, 0, 20, 10};
    vt[3] = '{1'b0, -1, 1'b1, 1'b1, 1'b1, 0, 20, 10};
    vt[4] = '{1'b1, -1, 1'b1, 1'b1, 1'b1, 0, 20, 10};
    vt[5] = '{1'b1,  8, 1'b1, 1'b0, 1'b0, 1,  0,  0};
    vt[6] = '{1'b0, -1, 1'b0, 1'b0, 1'b0, 1,  0,  0};
    vt[7] = '{1'b0, -1, 1'b0, 1'b0, 1'b0, 1,  0,  0};
    vt[8] = '{1'b0, -1, 1'b1, 1'b1, 1'b1, 1, 20, 10};
    vt[9] = '{1'b1, -1, 1'b1, 1'b0, 1'b1, 1, 20, 10};

    reset = 1'b1;
    hs = 1'b0; vs = 1'b0; {r, g, b} = 12'h000;
    repeat (3) cyc(1'b0, 1'b0, 12'h000);
    check_status("reset", 1'b0, 0, 0, 0);
    chk("reset_pixel_valid0", int'(pv0), 0);
    chk("reset_frame_sum0", int'(fsum0), 0);
    reset = 1'b0;
    repeat (5) cyc(1'b0, 1'b0, 12'h000);

    for (int i = 0; i < 10; i++) begin
      drive_frame(vt[i].pat, vt[i].bad_line, vt[i].push_pix, vt[i].push_sum, 10);
      check_status($sformatf("frame%0d", i), vt[i].exp_lock, vt[i].exp_err,
                   vt[i].exp_len, vt[i].exp_lines);
    end

    // hsync stuck inactive: counter saturates and lock is lost once.
    repeat (500) cyc(1'b0, 1'b0, 12'h0F0);
    check_status("stuck_early", 1'b1, 1, 20, 10);
    repeat (600) cyc(1'b0, 1'b0, 12'h0F0);
    check_status("stuck_late", 1'b0, 2, 0, 0);

    // Relock, then reset in the middle of a locked frame.
    drive_frame(1'b0, -1, 1'b0, 1'b0, 10);
    drive_frame(1'b0, -1, 1'b0, 1'b0, 10);
    drive_frame(1'b0, -1, 1'b1, 1'b1, 10);
    check_status("relock", 1'b1, 2, 20, 10);
    drive_frame(1'b0, -1, 1'b0, 1'b0, 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 12'h000);
    check_status("midreset", 1'b0, 0, 0, 0);
    chk("midreset_hpos0", int'(hpos0), 0);
    chk("midreset_vpos0", int'(vpos0), 0);
    chk("midreset_pixel_valid0", int'(pv0), 0);
    chk("midreset_pixel0", int'(pix0), 0);
    chk("midreset_frame_done0", int'(fd0), 0);
    chk("midreset_frame_sum0", int'(fsum0), 0);
    chk("midreset_frame_sum1", int'(fsum1), 0);
    reset = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 12'h000);
    drive_frame(1'b0, -1, 1'b0, 1'b0, 10);
    check_status("after_reset1", 1'b0, 0, 0, 0);
    drive_frame(1'b0, -1, 1'b0, 1'b0, 10);
    check_status("after_reset2", 1'b0, 0, 0, 0);
    drive_frame(1'b1, -1, 1'b1, 1'b0, 10);
    check_status("after_reset3", 1'b1, 0, 20, 10);

    repeat (30) cyc(1'b0, 1'b0, 12'h000);
    chk("pixel_queue_left", pq0.size() + pq1.size(), 0);
    chk("sum_queue_left", sq0.size() + sq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
